// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS-lite core.
//   RESET_PC_DEFAULT : default fetch PC after reset
//   fetch_state_t    : fetch FSM state (IDLE, WAIT)
//   ibuf_entry_t     : instruction-buffer entry {inst, pc}
package mips_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   typedef enum logic {IDLE, WAIT} fetch_state_t;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ibuf_entry_t;
endpackage

// File: rtl/if_ibuf.sv
// if_ibuf: small instruction FIFO toward decode with a registered head entry.
//   push/din : enqueue an entry (ignored when full unless popping)
//   pop      : dequeue the head (ignored when empty)
//   flush    : drop every entry
//   count    : entries held; valid = count != 0
//   head     : registered copy of the oldest entry
module if_ibuf
   import mips_pkg::*;
#(
   parameter int IBUF_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  ibuf_entry_t                      din,
   input  logic                             pop,
   input  logic                             flush,
   output logic [$clog2(IBUF_DEPTH+1)-1:0]  count,
   output logic                             valid,
   output ibuf_entry_t                      head
);
   localparam int AW = $clog2(IBUF_DEPTH);
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   ibuf_entry_t   mem [IBUF_DEPTH];
   logic [AW-1:0] wr, rd, wr_nxt, rd_nxt;
   logic          do_push, do_pop;
   assign valid   = count != '0;
   assign do_pop  = pop && valid;
   assign do_push = push && (count != CW'(IBUF_DEPTH) || do_pop);
   assign rd_nxt  = do_pop ? ((rd == AW'(IBUF_DEPTH - 1)) ? '0 : rd + AW'(1)) : rd;
   assign wr_nxt  = do_push ? ((wr == AW'(IBUF_DEPTH - 1)) ? '0 : wr + AW'(1)) : wr;
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   // The head is reloaded from the entry that becomes oldest; when that entry
   // is being written this same edge, it is forwarded straight from din.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
         head  <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         rd    <= rd_nxt;
         wr    <= wr_nxt;
         count <= count + CW'(do_push) - CW'(do_pop);
         head  <= (do_push && wr == rd_nxt) ? din : mem[rd_nxt];
      end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; holds the PC, issues single-outstanding
// fetches and buffers returned instructions toward decode.
//   pc/npc/redirect           : PC state and next-PC calculator interface
//   imem_req/addr/gnt/rvalid/rdata : instruction memory request/response
//   inst_valid/inst/inst_pc/inst_ready : ready/valid handshake to decode
//   fetch_err                 : sticky misaligned-PC flag, present only when
//                               IF_MISALIGN_CHECK_EN is defined
module if_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IBUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pc,
   input  logic [31:0] npc,
   input  logic        redirect,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic        fetch_err
`endif
);
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   localparam int OW = CW + 1;
   fetch_state_t  state;
   logic          drop;
   logic [31:0]   pend_pc;
   logic [CW-1:0] count;
   logic [OW-1:0] occ;
   ibuf_entry_t   head, din;
   logic          in_wait, rsp, push, pop, room, misalign, fire;
   assign in_wait = state == WAIT;
   assign rsp     = in_wait && imem_rvalid;
   assign push    = rsp && !drop && !redirect;
   assign pop     = inst_valid && inst_ready;
   // Occupancy after this cycle's push/pop; a new request needs a free slot
   // for its own response.
   assign occ     = {1'b0, count} + OW'(push) - OW'(pop);
   assign room    = occ < OW'(IBUF_DEPTH);
`ifdef IF_MISALIGN_CHECK_EN
   assign misalign  = !in_wait && |pc[1:0];
   assign imem_addr = pc;
`else
   assign misalign  = 1'b0;
   assign imem_addr = {pc[31:2], 2'b00};
`endif
   assign imem_req = rst_n && !redirect && (!in_wait || rsp) && room && !misalign;
   assign fire     = imem_req && imem_gnt;
   assign din      = '{inst: imem_rdata, pc: pend_pc};
   assign inst     = head.inst;
   assign inst_pc  = head.pc;
   // A redirect while a response is still owed marks that response for discard.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         drop    <= 1'b0;
         pend_pc <= '0;
      end else begin
         if (fire || redirect) pc <= npc;
         if (fire) pend_pc <= imem_addr;
         state <= fire ? WAIT : rsp ? IDLE : state;
         drop  <= redirect ? (fire || (in_wait && !imem_rvalid)) : rsp ? 1'b0 : drop;
      end
`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) fetch_err <= 1'b0;
      else fetch_err <= redirect ? |npc[1:0] : fetch_err | misalign;
`endif
   if_ibuf #(.IBUF_DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .flush (redirect),
      .count (count),
      .valid (inst_valid),
      .head  (head)
   );
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a one-slot memory model and an inst_pc scoreboard.
module tb_if_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   logic        clk, rst_n, redirect, imem_req, imem_gnt, imem_rvalid;
   logic        inst_valid, inst_ready;
   logic [31:0] pc, npc, imem_addr, imem_rdata, inst, inst_pc;
`ifdef IF_MISALIGN_CHECK_EN
   logic        fetch_err;
`endif
   int          vectors = 0, miscompares = 0;
   logic [31:0] sb [$];
   logic [31:0] tgt, pend_a;
   logic        mem_on, pend_v;

   if_fetch #(.RESET_PC(RST_PC), .IBUF_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .npc         (npc),
      .redirect    (redirect),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .fetch_err   (fetch_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h0F0F_F0F0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   // One clock: drive npc, sample handshakes, pop/compare the scoreboard,
   // then update the memory model after the edge.
   task automatic tick();
      logic        f, rv;
      logic [31:0] a, e;
      #1;
      npc = redirect ? tgt : pc + 32'd4;
      #1;
      f  = imem_req && imem_gnt;
      a  = imem_addr;
      rv = imem_rvalid;
      if (inst_valid && inst_ready) begin
         vectors++;
         assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_pop: observed inst_pc %h expected no instruction", inst_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_inst_pc", inst_pc, e);
            chk("sb_inst", inst, mem_word(e));
         end
      end
      @(posedge clk);
      #1;
      if (rv) pend_v = 1'b0;
      if (f) begin
         pend_v = 1'b1;
         pend_a = a;
      end
      imem_rvalid = pend_v && mem_on;
      imem_rdata  = pend_v ? mem_word(pend_a) : 32'h0;
      redirect    = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      chk1({tag, "_req"}, imem_req, 1'b0);
      chk1({tag, "_valid"}, inst_valid, 1'b0);
      chk({tag, "_inst"}, inst, 32'h0);
      chk({tag, "_inst_pc"}, inst_pc, 32'h0);
      chk({tag, "_pc"}, pc, RST_PC);
   endtask

   task automatic do_reset();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pend_v      = 1'b0;
      mem_on      = 1'b1;
      inst_ready  = 1'b1;
      #1;
      reset_checks("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; redirect = 1'b0; npc = 32'h0; imem_gnt = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b1;
      tgt = 32'h0; pend_a = 32'h0; pend_v = 1'b0; mem_on = 1'b1;
      @(negedge clk);

      // Streaming: one instruction per cycle, first one two cycles after the grant.
      do_reset();
      sb.push_back(32'h3000); sb.push_back(32'h3004); sb.push_back(32'h3008);
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'h3000);
      tick(); chk1("t1_v0", inst_valid, 1'b0);
      tick(); chk1("t1_v1", inst_valid, 1'b1); chk("t1_pc0", inst_pc, 32'h3000);
      tick(); chk("t1_pc1", inst_pc, 32'h3004);
      tick(); chk("t1_pc2", inst_pc, 32'h3008);
      tick();

      // Decode stall: buffer fills to two entries, requests stop, head held.
      do_reset();
      inst_ready = 1'b0;
      sb.push_back(32'h3000); sb.push_back(32'h3004);
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk1("t2_req", imem_req, 1'b0);
         chk1("t2_valid", inst_valid, 1'b1);
         chk("t2_inst_pc", inst_pc, 32'h3000);
         chk("t2_inst", inst, mem_word(32'h3000));
         tick();
      end
      inst_ready = 1'b1;
      #1;
      chk1("t2_req_resume", imem_req, 1'b1);
      chk("t2_addr_resume", imem_addr, 32'h3008);
      tick(); tick();
      chk("t2_refetch", inst_pc, 32'h3008);

      // Redirect while the 300C response is outstanding: that response is dropped.
      do_reset();
      sb.push_back(32'h3000); sb.push_back(32'h3004); sb.push_back(32'h3008); sb.push_back(32'h4000);
      tick(); tick(); tick();
      mem_on = 1'b0;
      tick();
      chk1("t3_req_wait", imem_req, 1'b0);
      chk("t3_pc_before", inst_pc, 32'h3008);
      redirect = 1'b1; tgt = 32'h0000_4000; mem_on = 1'b1;
      tick();
      chk1("t3_valid_flushed", inst_valid, 1'b0);
      chk1("t3_req_target", imem_req, 1'b1);
      chk("t3_addr_target", imem_addr, 32'h4000);
      tick(); tick();
      chk("t3_first_target", inst_pc, 32'h4000);
      tick();

      // Redirect in the cycle the 3008 request would be issued.
      do_reset();
      sb.push_back(32'h3000); sb.push_back(32'h5000);
      tick(); tick();
      chk1("t4_req_pre", imem_req, 1'b1);
      chk("t4_addr_pre", imem_addr, 32'h3008);
      redirect = 1'b1; tgt = 32'h0000_5000;
      #1;
      chk1("t4_req_redir", imem_req, 1'b0);
      tick();
      chk1("t4_valid_flushed", inst_valid, 1'b0);
      chk1("t4_req_target", imem_req, 1'b1);
      chk("t4_addr_target", imem_addr, 32'h5000);
      tick(); tick();
      chk("t4_first_target", inst_pc, 32'h5000);
      tick();

      // Reset while waiting, then a stray response after release.
      do_reset();
      sb.push_back(32'h3000);
      mem_on = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      reset_checks("t5_rst");
      @(negedge clk);
      pend_v = 1'b0; mem_on = 1'b1; rst_n = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk1("t5_req", imem_req, 1'b1);
      chk("t5_addr", imem_addr, RST_PC);
      chk1("t5_valid0", inst_valid, 1'b0);
      tick();
      chk1("t5_stray_dropped", inst_valid, 1'b0);
      tick();
      chk1("t5_valid1", inst_valid, 1'b1);
      chk("t5_inst_pc", inst_pc, 32'h3000);
      chk("t5_inst", inst, mem_word(32'h3000));
      tick();

      // Redirect from IDLE near the top of memory; PC wraps to zero.
      do_reset();
      sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0000_0000);
      redirect = 1'b1; tgt = 32'hFFFF_FFF8;
      #1;
      chk1("t6_req_redir", imem_req, 1'b0);
      tick();
      chk1("t6_req", imem_req, 1'b1);
      chk("t6_addr", imem_addr, 32'hFFFF_FFF8);
      chk("t6_pc", pc, 32'hFFFF_FFF8);
      tick(); tick();
      chk("t6_pc0", inst_pc, 32'hFFFF_FFF8);
      tick(); chk("t6_pc1", inst_pc, 32'hFFFF_FFFC);
      tick(); chk("t6_pc2", inst_pc, 32'h0000_0000);
      tick();
      chk("sb_drained_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
